// File: rtl/clk_gate_ctrl.sv
// Enable sequencer for a SYNC-type BUFGCE. It turns level and counted-burst run requests
// into CE edges that respect settle time and minimum on/off dwell, and acknowledges the gated clock state.
module clk_gate_ctrl #(
  parameter int SETTLE_CYCLES = 3,
  parameter int MIN_ON        = 4,
  parameter int MIN_OFF       = 2,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_req,
  input  logic                 burst_start,
  input  logic [CNT_WIDTH-1:0] burst_len,
  output logic                 ce,
  output logic                 running,
  output logic                 busy,
  output logic                 burst_done
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int ON_W  = $clog2(MIN_ON + 1);
  localparam int OFF_W = $clog2(MIN_OFF + 1);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_STARTING,
    ST_ON,
    ST_STOPPING
  } state_t;

  state_t               state_q, state_d;
  logic                 ce_q, ce_d;
  logic                 running_q, running_d;
  logic                 busy_q, busy_d;
  logic                 burst_done_q, burst_done_d;
  logic [SET_W-1:0]     settle_q, settle_d;
  logic [ON_W-1:0]      on_hold_q, on_hold_d, on_hold_dec;
  logic [OFF_W-1:0]     off_hold_q, off_hold_d, off_hold_dec;
  logic [CNT_WIDTH-1:0] burst_cnt_q, burst_cnt_d;
  logic                 burst_accept;
  logic                 burst_pending;

  assign burst_accept  = burst_start && (burst_len != '0) && (burst_cnt_q == '0);
  assign burst_pending = (burst_cnt_q != '0) || burst_accept;

  // Hold counters hold the dwell still owed after the current cycle, so expiry is checked on the decremented value.
  assign on_hold_dec  = (on_hold_q  != '0) ? on_hold_q  - ON_W'(1)  : '0;
  assign off_hold_dec = (off_hold_q != '0) ? off_hold_q - OFF_W'(1) : '0;

  always_comb begin
    state_d      = state_q;
    ce_d         = ce_q;
    running_d    = running_q;
    settle_d     = settle_q;
    on_hold_d    = on_hold_q;
    off_hold_d   = off_hold_q;
    burst_cnt_d  = burst_cnt_q;
    burst_done_d = 1'b0;

    if (burst_accept) begin
      burst_cnt_d = burst_len;
    end

    case (state_q)
      ST_OFF: begin
        off_hold_d = off_hold_dec;
        if ((off_hold_dec == '0) && (en_req || burst_pending)) begin
          state_d  = ST_STARTING;
          ce_d     = 1'b1;
          settle_d = SET_W'(SETTLE_CYCLES - 1);
        end
      end

      ST_STARTING: begin
        if (settle_q == '0) begin
          state_d   = ST_ON;
          running_d = 1'b1;
          on_hold_d = ON_W'(MIN_ON);
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end

      // The burst counter only advances on cycles the gated clock is confirmed running.
      ST_ON: begin
        on_hold_d = on_hold_dec;
        if (burst_cnt_q != '0) begin
          burst_cnt_d  = burst_cnt_q - CNT_WIDTH'(1);
          burst_done_d = (burst_cnt_q == CNT_WIDTH'(1));
        end
        if ((on_hold_dec == '0) && !en_req && (burst_cnt_d == '0)) begin
          state_d   = ST_STOPPING;
          ce_d      = 1'b0;
          running_d = 1'b0;
          settle_d  = SET_W'(SETTLE_CYCLES - 1);
        end
      end

      ST_STOPPING: begin
        if (settle_q == '0) begin
          state_d    = ST_OFF;
          off_hold_d = OFF_W'(MIN_OFF);
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end

      default: begin
        state_d   = ST_OFF;
        ce_d      = 1'b0;
        running_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_OFF) || (burst_cnt_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_OFF;
      ce_q         <= 1'b0;
      running_q    <= 1'b0;
      busy_q       <= 1'b0;
      burst_done_q <= 1'b0;
      settle_q     <= '0;
      on_hold_q    <= '0;
      off_hold_q   <= OFF_W'(MIN_OFF);
      burst_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      ce_q         <= ce_d;
      running_q    <= running_d;
      busy_q       <= busy_d;
      burst_done_q <= burst_done_d;
      settle_q     <= settle_d;
      on_hold_q    <= on_hold_d;
      off_hold_q   <= off_hold_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

  assign ce         = ce_q;
  assign running    = running_q;
  assign busy       = busy_q;
  assign burst_done = burst_done_q;

endmodule
